// File: rtl/neosd_dat_crc.sv
// -----------------------------------------------------------------------------
// neosd_dat_crc
// Serial CRC16 (x^16+x^12+x^5+1, init 0, MSB-first) for one SD DAT line.
// Transmit: accumulate outgoing data bits, then shift the CRC out MSB-first.
// Receive : accumulate data plus received CRC; a zero residue means valid.
//
// Ports:
//   clk_i       system clock, rising-edge
//   rst_i       synchronous active-high reset (clears the CRC)
//   clkstrb_i   SD bit-clock strobe; the register only changes when it is 1
//   data_s_i    serial data bit fed into the CRC
//   shift_s_i   accumulate mode
//   output_s_i  output mode (priority over accumulate): plain left shift
//   data_s_o    crc[15], combinational from the register
//   nonzero_o   OR-reduction of the register, combinational
// -----------------------------------------------------------------------------
module neosd_dat_crc (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clkstrb_i,
    input  logic data_s_i,
    input  logic shift_s_i,
    input  logic output_s_i,
    output logic data_s_o,
    output logic nonzero_o
);

    localparam int unsigned CRC_W = 16;
    localparam logic [CRC_W-1:0] POLY = 16'h1021;

    logic [CRC_W-1:0] crc;
    logic [CRC_W-1:0] crc_next;
    logic             fb;

    // Next-state selection; output mode shifts zeros in so the register
    // drains to 0 after 16 strobes, ready for the next block.
    always_comb begin
        crc_next = crc;
        fb       = data_s_i ^ crc[CRC_W-1];
        if (output_s_i) begin
            crc_next = {crc[CRC_W-2:0], 1'b0};
        end else if (shift_s_i) begin
            crc_next = {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : CRC_W'(0));
        end
    end

    // CRC register, advanced only on bit-clock strobes
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            crc <= '0;
        end else if (clkstrb_i) begin
            crc <= crc_next;
        end
    end

    assign data_s_o  = crc[CRC_W-1];
    assign nonzero_o = |crc;

endmodule

// File: tb/tb_neosd_dat_crc.sv
// -----------------------------------------------------------------------------
// tb_neosd_dat_crc
// Self-checking bench: a polynomial-remainder model of the CRC register is
// compared against data_s_o / nonzero_o every cycle, plus literal checks of
// known CRC values (ASCII "123456789" -> 0x31C3, 512 x 0xFF -> 0x7FA1).
// -----------------------------------------------------------------------------
module tb_neosd_dat_crc;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic clkstrb_i = 1'b0;
    logic data_s_i = 1'b0;
    logic shift_s_i = 1'b0;
    logic output_s_i = 1'b0;
    logic data_s_o;
    logic nonzero_o;

    int total = 0;
    int bad   = 0;

    logic [15:0] model = 16'h0000;
    bit          started = 1'b0;
    bit          done = 1'b0;

    neosd_dat_crc dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clkstrb_i  (clkstrb_i),
        .data_s_i   (data_s_i),
        .shift_s_i  (shift_s_i),
        .output_s_i (output_s_i),
        .data_s_o   (data_s_o),
        .nonzero_o  (nonzero_o)
    );

    always #5 clk_i = ~clk_i;

    // Remainder of (r(x)*x + b*x^16) modulo P(x) = x^16+x^12+x^5+1
    function automatic logic [15:0] mod_step(input logic [15:0] r, input logic b);
        logic [16:0] t;
        t = {r, 1'b0} ^ {b, 16'h0000};
        if (t[16]) t = t ^ 17'h11021;
        return t[15:0];
    endfunction

    function automatic logic [15:0] feed16(input logic [15:0] start, input logic [15:0] bits);
        logic [15:0] r;
        r = start;
        for (int i = 15; i >= 0; i--) r = mod_step(r, bits[i]);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model of the register, evaluated at each rising edge
    always @(posedge clk_i) begin
        if (rst_i) begin
            model   = 16'h0000;
            started = 1'b1;
        end else if (clkstrb_i) begin
            if (output_s_i)     model = {model[14:0], 1'b0};
            else if (shift_s_i) model = mod_step(model, data_s_i);
        end
    end

    // Cycle-by-cycle comparison on the falling edge
    always @(negedge clk_i) begin
        if (started && !done) begin
            check("data_s_o", 32'(data_s_o), 32'(model[15]));
            check("nonzero_o", 32'(nonzero_o), 32'(model != 16'h0000));
        end
    end

    task automatic step(input logic s, input logic d, input logic sh, input logic o);
        clkstrb_i  = s;
        data_s_i   = d;
        shift_s_i  = sh;
        output_s_i = o;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_i = 1'b1;
        for (int i = 0; i < n; i++)
            step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        rst_i = 1'b0;
    endtask

    task automatic feed_byte(input logic [7:0] b, input bit idle);
        for (int i = 7; i >= 0; i--) begin
            if (idle) begin
                int n;
                n = int'($urandom_range(0, 3));
                for (int k = 0; k < n; k++) begin
                    if ($urandom_range(0, 1) == 0)
                        step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
                    else
                        step(1'b1, 1'($urandom), 1'b0, 1'b0);
                end
            end
            step(1'b1, b[i], 1'b1, 1'b0);
        end
    endtask

    // Shift the CRC out, sampling data_s_o before each output strobe
    task automatic dump(output logic [15:0] v);
        for (int i = 15; i >= 0; i--) begin
            v[i] = data_s_o;
            step(1'b1, 1'($urandom), 1'($urandom), 1'b1);
        end
    endtask

    initial begin
        logic [7:0]  msg [9];
        logic [15:0] v;
        logic [15:0] saved;
        logic [15:0] m;
        logic [15:0] flip;

        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

        // Reset with random activity on all inputs
        do_reset(2);
        check("reset_data", 32'(data_s_o), 32'h0);
        check("reset_nonzero", 32'(nonzero_o), 32'h0);

        // "123456789" -> 0x31C3, then drain via output mode
        for (int i = 0; i < 9; i++) feed_byte(msg[i], 1'b0);
        check("model_31c3", 32'(model), 32'h31C3);
        check("nz_31c3", 32'(nonzero_o), 32'h1);
        dump(v);
        check("dump_31c3", 32'(v), 32'h31C3);
        check("drained_nz", 32'(nonzero_o), 32'h0);

        // Same message with idle cycles interleaved, no reset in between
        for (int i = 0; i < 9; i++) feed_byte(msg[i], 1'b1);
        dump(v);
        check("dump_idle_31c3", 32'(v), 32'h31C3);

        // 512 bytes of 0xFF -> 0x7FA1, then residue check
        for (int i = 0; i < 512; i++) feed_byte(8'hFF, 1'b0);
        check("model_7fa1", 32'(model), 32'h7FA1);
        for (int i = 15; i >= 0; i--) step(1'b1, saved_bit(16'h7FA1, i), 1'b1, 1'b0);
        check("residue_ok", 32'(nonzero_o), 32'h0);

        // Same block with one CRC bit flipped -> error
        flip = 16'h7FA1 ^ (16'h0001 << $urandom_range(0, 15));
        for (int i = 0; i < 512; i++) feed_byte(8'hFF, 1'b0);
        for (int i = 15; i >= 0; i--) step(1'b1, flip[i], 1'b1, 1'b0);
        check("residue_bad", 32'(nonzero_o), 32'h1);
        do_reset(1);

        // Strobe gating: accumulate mode without strobes must hold
        for (int i = 0; i < 20; i++) step(1'b1, 1'($urandom), 1'b1, 1'b0);
        saved = model;
        for (int i = 0; i < 10; i++) step(1'b0, 1'($urandom), 1'b1, 1'($urandom));
        check("gate_model", 32'(model), 32'(saved));
        dump(v);
        check("gate_dump", 32'(v), 32'(saved));

        // Priority: find a 16-bit input that produces 0x8001 from zero
        m = 16'h0000;
        for (int k = 0; k < 65536; k++) begin
            if (feed16(16'h0000, 16'(k)) == 16'h8001) m = 16'(k);
        end
        do_reset(1);
        for (int i = 15; i >= 0; i--) step(1'b1, m[i], 1'b1, 1'b0);
        check("model_8001", 32'(model), 32'h8001);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("prio_model", 32'(model), 32'h0002);
        // Hold with strobe and both modes low
        for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom), 1'b0, 1'b0);
        dump(v);
        check("prio_dump", 32'(v), 32'h0002);

        // Mid-operation reset discards the partial CRC
        for (int i = 0; i < 20; i++) step(1'b1, 1'($urandom), 1'b1, 1'b0);
        do_reset(1);
        check("midrst_nz", 32'(nonzero_o), 32'h0);
        for (int i = 0; i < 9; i++) feed_byte(msg[i], 1'b0);
        dump(v);
        check("midrst_31c3", 32'(v), 32'h31C3);

        // Fully random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst_i = ($urandom_range(0, 99) == 0);
            step(1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
        end
        rst_i = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);

        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    function automatic logic saved_bit(input logic [15:0] w, input int i);
        return w[i];
    endfunction

endmodule
